// File: rtl/alu_pkg.sv
// Shared ALU decoder constants: ALUControl operation encodings and
// main-decoder ALUOp classes.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_RSVD  = 2'b11;

  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_SLT    = 3'b010;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_AND    = 3'b111;

endpackage

// File: rtl/alu_dec_logic.sv
// Combinational ALU decode from ALUOp and instruction funct fields.
// Unsupported or non-matching codes fall through to ADD with illegal set.
module alu_dec_logic
  import alu_pkg::*;
(
  input  logic       opb5,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic [1:0] ALUOp,
  output logic [2:0] control,
  output logic       illegal
);

  // Decode operation; any code without an explicit match lands on ADD/illegal
  always_comb begin
    control = ALU_ADD;
    illegal = 1'b0;
    case (ALUOp)
      ALUOP_ADD: begin
        control = ALU_ADD;
        illegal = 1'b0;
      end
      ALUOP_SUB: begin
        control = ALU_SUB;
        illegal = 1'b0;
      end
      ALUOP_FUNCT: begin
        case (funct3)
          F3_ADDSUB: begin
            // Only R-type sub; addi with imm[10] set keeps ADD
            if (opb5 && funct7b5) begin
              control = ALU_SUB;
            end else begin
              control = ALU_ADD;
            end
            illegal = 1'b0;
          end
          F3_SLT: begin
            control = ALU_SLT;
            illegal = 1'b0;
          end
          F3_OR: begin
            control = ALU_OR;
            illegal = 1'b0;
          end
          F3_AND: begin
            control = ALU_AND;
            illegal = 1'b0;
          end
          default: begin
            control = ALU_ADD;
            illegal = 1'b1;
          end
        endcase
      end
      default: begin
        control = ALU_ADD;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_dec.sv
// Registered ALU decoder: combinational decode followed by a single
// output register, one result per cycle with one-cycle latency.
module alu_dec
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       opb5,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic [1:0] ALUOp,
  output logic [2:0] ALUControl,
  output logic       illegal
);

  logic [2:0] control_d;
  logic       illegal_d;
  logic [2:0] control_q;
  logic       illegal_q;

  alu_dec_logic u_logic (
    .opb5     (opb5),
    .funct3   (funct3),
    .funct7b5 (funct7b5),
    .ALUOp    (ALUOp),
    .control  (control_d),
    .illegal  (illegal_d)
  );

  // Output register; async reset clears any pending decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      control_q <= ALU_ADD;
      illegal_q <= 1'b0;
    end else begin
      control_q <= control_d;
      illegal_q <= illegal_d;
    end
  end

  assign ALUControl = control_q;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_alu_dec.sv
// Self-checking bench for alu_dec: directed vector table plus
// hand-written reset and latency sequences.
module tb_alu_dec;

  typedef struct {
    logic [1:0] op;
    logic [2:0] f3;
    logic       opb5;
    logic       f7;
    logic [2:0] exp_ctl;
    logic       exp_ill;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       opb5;
  logic [2:0] funct3;
  logic       funct7b5;
  logic [1:0] ALUOp;
  logic [2:0] ALUControl;
  logic       illegal;

  int checks;
  int failures;

  vec_t vecs[20];

  alu_dec dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opb5       (opb5),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .ALUOp      (ALUOp),
    .ALUControl (ALUControl),
    .illegal    (illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [2:0] exp_ctl, input logic exp_ill);
    checks = checks + 1;
    if (ALUControl !== exp_ctl || illegal !== exp_ill) begin
      failures = failures + 1;
      $display("FAIL %s: got ctl=%b ill=%b, expected ctl=%b ill=%b",
               name, ALUControl, illegal, exp_ctl, exp_ill);
    end
  endtask

  task automatic set_in(input logic [1:0] op, input logic [2:0] f3, input logic b5, input logic f7);
    ALUOp    = op;
    funct3   = f3;
    opb5     = b5;
    funct7b5 = f7;
  endtask

  initial begin
    logic [2:0] prev_ctl;
    logic       prev_ill;

    checks   = 0;
    failures = 0;

    vecs[0]  = '{2'b00, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0};
    vecs[1]  = '{2'b00, 3'b111, 1'b1, 1'b1, 3'b000, 1'b0};
    vecs[2]  = '{2'b01, 3'b000, 1'b0, 1'b0, 3'b001, 1'b0};
    vecs[3]  = '{2'b01, 3'b110, 1'b1, 1'b1, 3'b001, 1'b0};
    vecs[4]  = '{2'b11, 3'b000, 1'b0, 1'b0, 3'b000, 1'b1};
    vecs[5]  = '{2'b11, 3'b111, 1'b1, 1'b1, 3'b000, 1'b1};
    vecs[6]  = '{2'b10, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0};
    vecs[7]  = '{2'b10, 3'b000, 1'b0, 1'b1, 3'b000, 1'b0};
    vecs[8]  = '{2'b10, 3'b000, 1'b1, 1'b0, 3'b000, 1'b0};
    vecs[9]  = '{2'b10, 3'b000, 1'b1, 1'b1, 3'b001, 1'b0};
    vecs[10] = '{2'b10, 3'b010, 1'b1, 1'b0, 3'b101, 1'b0};
    vecs[11] = '{2'b10, 3'b110, 1'b1, 1'b0, 3'b011, 1'b0};
    vecs[12] = '{2'b10, 3'b111, 1'b1, 1'b0, 3'b010, 1'b0};
    vecs[13] = '{2'b10, 3'b001, 1'b1, 1'b0, 3'b000, 1'b1};
    vecs[14] = '{2'b10, 3'b011, 1'b0, 1'b0, 3'b000, 1'b1};
    vecs[15] = '{2'b10, 3'b100, 1'b1, 1'b1, 3'b000, 1'b1};
    vecs[16] = '{2'b10, 3'b101, 1'b1, 1'b1, 3'b000, 1'b1};
    vecs[17] = '{2'b10, 3'b111, 1'b0, 1'b0, 3'b010, 1'b0};
    vecs[18] = '{2'b10, 3'b010, 1'b0, 1'b1, 3'b101, 1'b0};
    vecs[19] = '{2'b00, 3'b010, 1'b1, 1'b1, 3'b000, 1'b0};

    // Reset asserted with an OR decode on the inputs, before any clock edge
    rst_n = 1'b0;
    set_in(2'b10, 3'b110, 1'b1, 1'b0);
    #2;
    check("reset_no_clk", 3'b000, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_held_with_clk", 3'b000, 1'b0);

    rst_n = 1'b1;
    prev_ctl = 3'b000;
    prev_ill = 1'b0;

    for (int i = 0; i < 20; i++) begin
      set_in(vecs[i].op, vecs[i].f3, vecs[i].opb5, vecs[i].f7);
      #1;
      check($sformatf("hold_before_edge[%0d]", i), prev_ctl, prev_ill);
      @(posedge clk);
      #1;
      check($sformatf("vec[%0d]", i), vecs[i].exp_ctl, vecs[i].exp_ill);
      prev_ctl = vecs[i].exp_ctl;
      prev_ill = vecs[i].exp_ill;
    end

    // Mid-stream reset discards a pending AND decode
    set_in(2'b01, 3'b000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("pre_reset_sub", 3'b001, 1'b0);
    set_in(2'b10, 3'b111, 1'b0, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    check("midstream_reset_immediate", 3'b000, 1'b0);
    @(posedge clk);
    #1;
    check("midstream_reset_hold", 3'b000, 1'b0);
    set_in(2'b10, 3'b010, 1'b1, 1'b0);
    #1;
    rst_n = 1'b1;
    #1;
    check("release_before_edge", 3'b000, 1'b0);
    @(posedge clk);
    #1;
    check("first_edge_after_release", 3'b101, 1'b0);
    set_in(2'b11, 3'b010, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("after_release_rsvd", 3'b000, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
